npc_unit: RTL and testbench

Control-flow resolution stage directly downstream of the fetch/decode controller. It consumes decoded BRANCH, JAL, JALR and AUIPC instructions, which are the ones that make fetch stall. It waits for source operands, then computes the next PC and pulses `get_npc` to release fetch. It also produces the link/AUIPC write-back to the register file.

---
 rtl/npc_unit.sv | 162 ++++++++++++++++
 tb/tb_npc_unit.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npc_unit.sv
// npc_unit: resolves the next PC for BRANCH, JAL, JALR and AUIPC and
// releases the stalled fetch stage with a one-cycle get_npc pulse. It also
// produces the link / AUIPC register write-back.
// Optional feature: define NPC_MISALIGN_CHECK_EN to flag targets that are not
// 4-byte aligned and to suppress the write-back of such instructions.
module npc_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid,
  input  logic [6:0]      opcode,
  input  logic [2:0]      fun3,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] opc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            rs_ready,
  output logic [XLEN-1:0] npc,
  output logic            get_npc,
  output logic            busy,
  output logic            wb_en,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            misalign
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t          state;
  logic [6:0]      op_q;
  logic [2:0]      fun3_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] imm_q;
  logic [XLEN-1:0] opc_q;

  logic            accept_ok;
  logic            needs_rs;
  logic            enter_done;
  logic            taken;
  logic            has_wb;
  logic            wb_block;
  logic [XLEN-1:0] pc_imm;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] link;

  // Decode the held instruction into its target, link value and branch outcome
  always_comb begin
    accept_ok  = (opcode == OP_BRANCH) || (opcode == OP_JAL) ||
                 (opcode == OP_JALR) || (opcode == OP_AUIPC);
    needs_rs   = (op_q == OP_BRANCH) || (op_q == OP_JALR);
    enter_done = (state == S_WAIT) && (!needs_rs || rs_ready);
    has_wb     = (op_q != OP_BRANCH) && (rd_q != 5'd0);
    pc_imm     = opc_q + imm_q;
    pc_plus4   = opc_q + XLEN'(4);
    jalr_sum   = rs1_data + imm_q;
    taken      = 1'b0;
    case (fun3_q)
      3'b000:  taken = (rs1_data == rs2_data);
      3'b001:  taken = (rs1_data != rs2_data);
      3'b100:  taken = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  taken = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  taken = (rs1_data <  rs2_data);
      3'b111:  taken = (rs1_data >= rs2_data);
      default: taken = 1'b0;
    endcase
    target = pc_plus4;
    link   = pc_plus4;
    case (op_q)
      OP_JAL:    target = pc_imm;
      OP_JALR:   target = {jalr_sum[XLEN-1:1], 1'b0};
      OP_AUIPC:  link   = pc_imm;
      OP_BRANCH: if (taken) target = pc_imm;
      default:   target = pc_plus4;
    endcase
  end

`ifdef NPC_MISALIGN_CHECK_EN
  logic redirect;
  logic target_bad;

  // Only real redirects can be misaligned; fall-through and AUIPC never are
  always_comb begin
    redirect   = (op_q == OP_JAL) || (op_q == OP_JALR) ||
                 ((op_q == OP_BRANCH) && taken);
    target_bad = redirect && (target[1:0] != 2'b00);
    wb_block   = target_bad;
  end

  // Misalign flag accompanies get_npc for exactly the DONE cycle
  always_ff @(posedge clk) begin
    if (!rst_n) misalign <= 1'b0;
    else        misalign <= enter_done && target_bad;
  end
`else
  assign wb_block = 1'b0;
  assign misalign = 1'b0;
`endif

  // Control FSM: capture in IDLE, wait for operands, publish results in DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      op_q    <= '0;
      fun3_q  <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      opc_q   <= '0;
      npc     <= '0;
      get_npc <= 1'b0;
      busy    <= 1'b0;
      wb_en   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (valid && accept_ok) begin
            op_q   <= opcode;
            fun3_q <= fun3;
            rd_q   <= rd;
            imm_q  <= imm;
            opc_q  <= opc;
            busy   <= 1'b1;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (enter_done) begin
            npc     <= target;
            get_npc <= 1'b1;
            wb_en   <= has_wb && !wb_block;
            wb_rd   <= rd_q;
            wb_data <= link;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          get_npc <= 1'b0;
          wb_en   <= 1'b0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          get_npc <= 1'b0;
          wb_en   <= 1'b0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_npc_unit.sv
// Testbench for npc_unit: scenario tasks drive instructions and push the
// expected resolution into a scoreboard; a monitor pops and compares it
// whenever get_npc is seen. Build with NPC_MISALIGN_CHECK_EN to expect the
// misalignment behaviour.
module tb_npc_unit;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_ALU    = 7'b0110011;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [6:0]  opcode;
  logic [2:0]  fun3;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic [31:0] opc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        rs_ready;
  logic [31:0] npc;
  logic        get_npc;
  logic        busy;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;

  typedef struct {
    string       name;
    logic [31:0] npc;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    bit          chk_wb;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  npc_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .opcode(opcode), .fun3(fun3),
    .rd(rd), .imm(imm), .opc(opc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs_ready(rs_ready), .npc(npc), .get_npc(get_npc), .busy(busy),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every get_npc must match the oldest expected entry
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && get_npc) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_get_npc: got get_npc=1 npc=%h, required no pulse", npc);
      end else begin
        e = sb.pop_front();
        checks++;
        if (npc !== e.npc) begin
          errors++;
          $display("[TB] FAIL %s.npc: got %h required %h", e.name, npc, e.npc);
        end
        checks++;
        if (wb_en !== e.wb_en) begin
          errors++;
          $display("[TB] FAIL %s.wb_en: got %b required %b", e.name, wb_en, e.wb_en);
        end
        checks++;
        if (misalign !== e.mis) begin
          errors++;
          $display("[TB] FAIL %s.misalign: got %b required %b", e.name, misalign, e.mis);
        end
        if (e.chk_wb) begin
          checks++;
          if (wb_rd !== e.wb_rd) begin
            errors++;
            $display("[TB] FAIL %s.wb_rd: got %0d required %0d", e.name, wb_rd, e.wb_rd);
          end
          checks++;
          if (wb_data !== e.wb_data) begin
            errors++;
            $display("[TB] FAIL %s.wb_data: got %h required %h", e.name, wb_data, e.wb_data);
          end
        end
      end
    end
  end

  function automatic logic exp_mis(input logic redirect, input logic [31:0] t);
`ifdef NPC_MISALIGN_CHECK_EN
    return redirect && (t[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic br_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic push_exp(input string name, input logic [31:0] n, input logic we,
                          input logic [4:0] r, input logic [31:0] d, input bit cw,
                          input logic redirect);
    exp_t e;
    e.name    = name;
    e.npc     = n;
    e.mis     = exp_mis(redirect, n);
    e.wb_en   = we && !e.mis;
    e.wb_rd   = r;
    e.wb_data = d;
    e.chk_wb  = cw;
    sb.push_back(e);
  endtask

  // Present one instruction for a single accepting edge once the unit is free
  task automatic present(input logic [6:0] op, input logic [2:0] f, input logic [4:0] r,
                         input logic [31:0] im, input logic [31:0] pc);
    for (int i = 0; i < 50 && busy; i++) begin
      @(posedge clk); #1;
    end
    opcode = op; fun3 = f; rd = r; imm = im; opc = pc;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  // Advance edges until get_npc, raising rs_ready after ready_delay edges
  task automatic wait_npc(input int ready_delay, input int max_cycles,
                          output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < max_cycles) begin
      rs_ready = (cycles >= ready_delay);
      @(posedge clk); #1;
      cycles++;
      if (get_npc) seen = 1'b1;
    end
    rs_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (npc !== 32'h0)   begin errors++; $display("[TB] FAIL reset.npc: got %h required 0", npc); end
    checks++; if (get_npc !== 1'b0) begin errors++; $display("[TB] FAIL reset.get_npc: got %b required 0", get_npc); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("[TB] FAIL reset.busy: got %b required 0", busy); end
    checks++; if (wb_en !== 1'b0)   begin errors++; $display("[TB] FAIL reset.wb_en: got %b required 0", wb_en); end
    checks++; if (wb_rd !== 5'd0)   begin errors++; $display("[TB] FAIL reset.wb_rd: got %0d required 0", wb_rd); end
    checks++; if (wb_data !== 32'h0) begin errors++; $display("[TB] FAIL reset.wb_data: got %h required 0", wb_data); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("[TB] FAIL reset.misalign: got %b required 0", misalign); end
  endtask

  task automatic test_jal;
    int cyc; bit seen;
    push_exp("jal", 32'h120, 1'b1, 5'd1, 32'h104, 1'b1, 1'b1);
    present(OP_JAL, 3'd0, 5'd1, 32'h20, 32'h100);
    wait_npc(100, 20, cyc, seen);
    checks++; if (!seen || cyc !== 1) begin errors++; $display("[TB] FAIL jal.latency: got seen=%b cycles=%0d required 1", seen, cyc); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL jal.busy_done: got %b required 1", busy); end
    @(posedge clk); #1;
    checks++; if (get_npc !== 1'b0) begin errors++; $display("[TB] FAIL jal.pulse_width: got %b required 0", get_npc); end
    checks++; if (wb_en !== 1'b0)   begin errors++; $display("[TB] FAIL jal.wb_pulse: got %b required 0", wb_en); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("[TB] FAIL jal.busy_idle: got %b required 0", busy); end
    checks++; if (npc !== 32'h120)  begin errors++; $display("[TB] FAIL jal.npc_hold: got %h required 120", npc); end
  endtask

  task automatic test_branch;
    int cyc; bit seen;
    logic [31:0] a, b, pc, im;
    logic [4:0] r;
    logic t;
    rs1_data = 32'hFFFFFFFF; rs2_data = 32'h1;
    push_exp("blt", 32'h1F0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    present(OP_BRANCH, 3'b100, 5'd7, 32'hFFFFFFF0, 32'h200);
    wait_npc(3, 20, cyc, seen);
    checks++; if (!seen || cyc !== 4) begin errors++; $display("[TB] FAIL blt.latency: got seen=%b cycles=%0d required 4", seen, cyc); end
    push_exp("bltu", 32'h204, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    present(OP_BRANCH, 3'b110, 5'd7, 32'hFFFFFFF0, 32'h200);
    wait_npc(0, 20, cyc, seen);
    checks++; if (!seen || cyc !== 1) begin errors++; $display("[TB] FAIL bltu.latency: got seen=%b cycles=%0d required 1", seen, cyc); end
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < 2; k++) begin
        a  = $urandom;
        b  = (k == 0) ? a : $urandom;
        pc = $urandom & 32'hFFFFFFFC;
        im = $urandom & 32'hFFFFFFFC;
        r  = 5'($urandom_range(1, 31));
        rs1_data = a; rs2_data = b;
        t = br_taken(3'(f), a, b);
        push_exp($sformatf("br_f%0d_%0d", f, k), t ? pc + im : pc + 32'd4, 1'b0, 5'd0, 32'h0, 1'b0, t);
        present(OP_BRANCH, 3'(f), r, im, pc);
        wait_npc(k, 20, cyc, seen);
        checks++; if (!seen) begin errors++; $display("[TB] FAIL br_f%0d_%0d.timeout: got no get_npc required pulse", f, k); end
      end
    end
  endtask

  task automatic test_jalr;
    int cyc; bit seen;
    rs1_data = 32'h1003; rs2_data = 32'h0;
    push_exp("jalr_odd", 32'h1002, 1'b0, 5'd0, 32'h304, 1'b1, 1'b1);
    present(OP_JALR, 3'd0, 5'd0, 32'h0, 32'h300);
    wait_npc(2, 20, cyc, seen);
    checks++; if (!seen || cyc !== 3) begin errors++; $display("[TB] FAIL jalr_odd.latency: got seen=%b cycles=%0d required 3", seen, cyc); end
    rs1_data = 32'hFFFFFFFC;
    push_exp("jalr_wrap", 32'h4, 1'b1, 5'd3, 32'h404, 1'b1, 1'b1);
    present(OP_JALR, 3'd0, 5'd3, 32'h8, 32'h400);
    wait_npc(0, 20, cyc, seen);
    checks++; if (!seen) begin errors++; $display("[TB] FAIL jalr_wrap.timeout: got no get_npc required pulse"); end
    present(OP_ALU, 3'd0, 5'd4, 32'h10, 32'h500);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ignored_opcode.busy: got %b required 0", busy); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_auipc;
    int pulses;
    push_exp("auipc", 32'h44, 1'b1, 5'd5, 32'h12345040, 1'b1, 1'b0);
    present(OP_AUIPC, 3'd0, 5'd5, 32'h12345000, 32'h40);
    opcode = OP_JAL; rd = 5'd9; imm = 32'h800; opc = 32'h900;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    checks++; if (get_npc !== 1'b1) begin errors++; $display("[TB] FAIL auipc.get_npc: got %b required 1", get_npc); end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (get_npc) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL auipc.second_pulse: got %0d pulses required 0", pulses); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL auipc.busy_after: got %b required 0", busy); end
  endtask

  task automatic test_back_to_back;
    int cyc; bit seen;
    push_exp("b2b_first", 32'h1010, 1'b1, 5'd2, 32'h1004, 1'b1, 1'b1);
    present(OP_JAL, 3'd0, 5'd2, 32'h10, 32'h1000);
    wait_npc(0, 20, cyc, seen);
    checks++; if (!seen) begin errors++; $display("[TB] FAIL b2b_first.timeout: got no get_npc required pulse"); end
    push_exp("b2b_second", 32'h2100, 1'b1, 5'd6, 32'h2004, 1'b1, 1'b1);
    opcode = OP_JAL; fun3 = 3'd0; rd = 5'd6; imm = 32'h100; opc = 32'h2000;
    valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b.drop_in_done: got busy=%b required 0", busy); end
    @(posedge clk); #1;
    valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b.accept_idle: got busy=%b required 1", busy); end
    wait_npc(0, 20, cyc, seen);
    checks++; if (!seen || cyc !== 1) begin errors++; $display("[TB] FAIL b2b_second.latency: got seen=%b cycles=%0d required 1", seen, cyc); end
  endtask

  task automatic test_reset_mid;
    int pulses;
    rs1_data = 32'h5; rs2_data = 32'h5; rs_ready = 1'b0;
    present(OP_BRANCH, 3'b000, 5'd0, 32'h40, 32'h600);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (get_npc !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid.get_npc: got %b required 0", get_npc); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("[TB] FAIL reset_mid.busy: got %b required 0", busy); end
    checks++; if (npc !== 32'h0)    begin errors++; $display("[TB] FAIL reset_mid.npc: got %h required 0", npc); end
    checks++; if (wb_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_mid.wb_data: got %h required 0", wb_data); end
    rst_n = 1'b1;
    rs_ready = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (get_npc) pulses++;
    end
    rs_ready = 1'b0;
    checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL reset_mid.discard: got %0d pulses required 0", pulses); end
  endtask

  initial begin
    valid = 1'b0; opcode = '0; fun3 = '0; rd = '0; imm = '0; opc = '0;
    rs1_data = '0; rs2_data = '0; rs_ready = 1'b0; rst_n = 1'b0;
    $display("[TB] starting npc_unit bench");
    test_reset();
    test_jal();
    test_branch();
    test_jalr();
    test_auipc();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
